booth_seq_multiplier: RTL and testbench
=======================================

Name: booth_seq_multiplier

Overview:
Radix-2 Booth sequential multiplier. It owns the multiplier register pair (Q, Qm1), the accumulator A and the iteration counter, and it drives the add/subtract and arithmetic-shift sequence. Each step inspects the pair {Q[0], Qm1}, conditionally adds or subtracts the multiplicand into A, then arithmetically shifts {A, Q, Qm1} right by one. The block sits between the operand source and the result consumer and uses a start/busy/done handshake.

Parameters:
WIDTH, 4, operand width in bits (two's complement); WIDTH >= 2; product is 2*WIDTH bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin a multiply; sampled only in IDLE
multiplicand  input  WIDTH  signed operand M; captured on the accepting edge
multiplier  input  WIDTH  signed operand loaded into Q; captured on the accepting edge
product  output  2*WIDTH  signed result; held until the next completion or reset
busy  output  1  high while a multiply is in progress (ADD or SHIFT state)
done  output  1  one-cycle registered pulse when product is updated

Behaviour:
- Reset and clock: one clock, clk. rst is synchronous and active-high and has priority over everything. On a rst edge: state=IDLE, A=0, Q=0, Qm1=0, M=0, count=0, product=0, done=0. busy=0 follows from IDLE.
- Internal registers:
  - A: WIDTH+1 bits (one guard bit, so -M never overflows for M = -2^(WIDTH-1)).
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - Q: WIDTH bits.
  - Qm1: 1 bit.
  - count: clog2(WIDTH+1) bits.
- States: IDLE, ADD, SHIFT. busy = (state != IDLE), decoded from state.
- IDLE:
  - If start=1: A=0, M=sext(multiplicand), Q=multiplier, Qm1=0, count=WIDTH, then go to ADD.
  - Otherwise hold all state.
- ADD:
  - {Q[0],Qm1}=01: A = A + M.
  - {Q[0],Qm1}=10: A = A - M.
  - {Q[0],Qm1}=00 or 11: A unchanged.
  - Arithmetic is modulo 2^(WIDTH+1). Always go to SHIFT.
- SHIFT:
  - {A,Q,Qm1} = arithmetic right shift by 1: A[WIDTH] is replicated, Qm1 takes Q[0], Q[WIDTH-1] takes A[0].
  - count = count - 1.
  - If count was 1: product = {A_shifted[WIDTH-1:0], Q_shifted}, done=1, go to IDLE.
  - Otherwise go to ADD.
- done: 0 on every edge except the final SHIFT edge, so it is exactly one cycle wide.
- Latency: if start is sampled at edge 0, done=1 and busy=0 after edge 2*WIDTH (8 cycles for WIDTH=4). busy=1 for cycles 1 through 2*WIDTH.
- Throughput: one multiply per 2*WIDTH+1 cycles. start asserted in the done cycle is accepted (state is IDLE then).
- start while busy: ignored. The operation in flight continues unchanged, and no queued request is kept.
- Operand changes after the accepting edge have no effect.
- Reset mid-operation: the block aborts to the reset state. product is cleared to 0 and no done pulse is emitted.
- rst and start on the same edge: rst wins. The block stays in IDLE and start is not accepted.
- product does not change between done pulses.

Test Plan:
1. Reset and idle:
   - Hold rst 2 cycles, then release -> product=0, busy=0, done=0.
   - Idle 3 cycles with start=0 -> outputs unchanged.
2. Positive and mixed-sign operands (WIDTH=4):
   - M=0011, Q=0010 (3*2) -> done after exactly 8 cycles, product=8'h06.
   - M=1010, Q=0011 (-6*3) -> product=8'hEE (-18).
3. Extreme operands:
   - M=1000, Q=1000 (-8*-8) -> product=8'h40 (64), exercising the guard bit.
   - M=0111, Q=1000 (7*-8) -> product=8'hC8 (-56).
4. start while busy:
   - Start 5*5; on cycle 3 pulse start with M=1111, Q=1111 -> ignored, product=8'h19 at the original cycle 8, single done pulse.
5. Reset mid-operation and back-to-back:
   - Assert rst in cycle 4 of a 3*2 multiply -> busy=0, product=0, no done pulse.
   - Start again in the cycle after reset release -> product=8'h06 after 8 cycles.
   - Assert start in the done cycle -> accepted, second product after a further 8 cycles.
6. Exhaustive self-check:
   - All 256 signed 4-bit operand pairs -> product == $signed(M)*$signed(Q).
   - done is one cycle wide and busy has the 8-cycle profile for every pair.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: radix-2 Booth sequential signed multiplier with start/busy/done handshake
module booth_seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ADD, SHIFT} state_t;
  state_t state;
  logic [WIDTH:0] a, m, a_sum, a_sh;
  logic [WIDTH-1:0] q, q_sh;
  logic qm1;
  logic [CW-1:0] count;
  // A carries a guard bit so that subtracting the most negative M cannot overflow
  always_comb begin
    a_sum = (q[0] && !qm1) ? a - m : (!q[0] && qm1) ? a + m : a;
    a_sh = {a[WIDTH], a[WIDTH:1]};
    q_sh = {a[0], q[WIDTH-1:1]};
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      m <= '0;
      q <= '0;
      qm1 <= 1'b0;
      count <= '0;
      product <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= '0;
          m <= {multiplicand[WIDTH-1], multiplicand};
          q <= multiplier;
          qm1 <= 1'b0;
          count <= CW'(WIDTH);
          state <= ADD;
        end
        ADD: begin
          a <= a_sum;
          state <= SHIFT;
        end
        SHIFT: begin
          a <= a_sh;
          q <= q_sh;
          qm1 <= q[0];
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            product <= {a_sh[WIDTH-1:0], q_sh};
            done <= 1'b1;
            state <= IDLE;
          end else begin
            state <= ADD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: latency/product model checked every cycle, plus directed literal cases
module tb_booth_seq_multiplier;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] mc = '0, mp = '0;
  logic [2*W-1:0] product;
  logic busy, done;
  int compared = 0, mismatched = 0;
  bit chk_en = 1'b0;
  int left = 0;
  logic [2*W-1:0] pend = '0, exp_p = '0;
  logic exp_done = 1'b0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(mc), .multiplier(mp),
    .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a multiply is a fixed 2*W-edge delay followed by the signed product
  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      left = 0;
      exp_p = '0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        exp_p = pend;
        exp_done = 1'b1;
      end
    end else if (start) begin
      pend = $signed(mc) * $signed(mp);
      left = 2 * W;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("busy", busy, left > 0);
    check("done", done, exp_done);
    check("product", product, exp_p);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int n;
    mc = a;
    mp = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
    check("latency", n, 2 * W);
    check("result", product, exp);
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_product", product, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) tick();
    check("idle_product", product, 8'h00);
    check("idle_busy", busy, 1'b0);
    run(4'b0011, 4'b0010, 8'h06);
    run(4'b1010, 4'b0011, 8'hEE);
    run(4'b1000, 4'b1000, 8'h40);
    run(4'b0111, 4'b1000, 8'hC8);
    tick();
    // start pulse mid-flight must be ignored
    mc = 4'd5;
    mp = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    mc = 4'hF;
    mp = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 4; i <= 8; i++) tick();
    check("busy_ignore_done", done, 1'b1);
    check("busy_ignore_product", product, 8'h19);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("single_done", done, 1'b0);
    end
    // abort mid-operation
    mc = 4'd3;
    mp = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_product", product, 8'h00);
    check("abort_done", done, 1'b0);
    run(4'd3, 4'd2, 8'h06);
    run(4'd7, 4'd7, 8'h31);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_beats_start", busy, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] a, b;
      int p;
      a = W'(i >> W);
      b = W'(i);
      p = int'($signed(a)) * int'($signed(b));
      run(a, b, (2*W)'(p));
    end
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 2) == 0;
      mc = W'($urandom);
      mp = W'($urandom);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (12) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
